// File: rtl/calo_cell_arb.sv
// Command-port arbiter for the 32x32 calorimeter cell store.
// One fill stream writes cells and NREQ requesters read them. Fill has
// priority up to a starvation limit, and reads are granted round-robin.
// Read data returns to the owning requester, tagged by a one-hot valid.
module calo_cell_arb #(
  parameter int NREQ    = 4,
  parameter int RD_LAT  = 1,
  parameter int MAXFILL = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fill_valid,
  input  logic [4:0]        i_fill_eta,
  input  logic [4:0]        i_fill_phi,
  input  logic [7:0]        i_fill_et,
  input  logic [7:0]        i_fill_e,
  output logic              o_fill_ready,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [5*NREQ-1:0] i_req_eta,
  input  logic [5*NREQ-1:0] i_req_phi,
  output logic [NREQ-1:0]   o_req_ready,
  output logic              o_store_en,
  output logic              o_store_wr,
  output logic [9:0]        o_store_addr,
  output logic [7:0]        o_store_wet,
  output logic [7:0]        o_store_we,
  input  logic [7:0]        i_store_et,
  input  logic [7:0]        i_store_e,
  output logic [NREQ-1:0]   o_rsp_valid,
  output logic [7:0]        o_rsp_et,
  output logic [7:0]        o_rsp_e
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_rr_ptr;
  logic [7:0]      r_fill_run;
  logic            w_any_req;
  logic            w_fill_ok;
  logic            w_grant_fill;
  logic            w_grant_rd;
  logic            w_found;
  logic [PW-1:0]   w_cand;
  logic [PW-1:0]   w_win;
  logic [NREQ-1:0] w_win_oh;
  logic [4:0]      w_rd_eta;
  logic [4:0]      w_rd_phi;
  logic [NREQ-1:0] r_tag_p [RD_LAT+1];
  logic [7:0]      r_rsp_et;
  logic [7:0]      r_rsp_e;
  logic            w_rsp_hit;

  // Saturating count of consecutive fill grants taken over waiting reads
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Round-robin successor that wraps for non-power-of-two NREQ
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(NREQ-1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search starting at rr_ptr; first valid requester wins
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = r_rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i_req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
      w_cand = wrap_inc(w_cand);
    end
  end

  assign w_any_req = |i_req_valid;
  assign w_fill_ok = (r_fill_run < 8'(MAXFILL));
  // Readiness is forced low while reset is held, even with valids up
  assign w_grant_fill = ~i_rst & i_fill_valid & (~w_any_req | w_fill_ok);
  assign w_grant_rd   = ~i_rst & w_any_req & ~w_grant_fill;
  assign w_win_oh     = NREQ'(1) << w_win;
  assign w_rd_eta     = i_req_eta[5*int'(w_win) +: 5];
  assign w_rd_phi     = i_req_phi[5*int'(w_win) +: 5];

  assign o_fill_ready = w_grant_fill;
  assign o_req_ready  = w_grant_rd ? w_win_oh : '0;

  // Arbiter state: round-robin pointer and fill starvation counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr   <= '0;
      r_fill_run <= '0;
    end else begin
      if (w_grant_rd) r_rr_ptr <= wrap_inc(w_win);
      if (w_grant_rd || !w_any_req) r_fill_run <= '0;
      else if (w_grant_fill)        r_fill_run <= sat_inc8(r_fill_run);
    end
  end

  // Store command register, loaded in the grant cycle; fields hold when idle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_store_en   <= 1'b0;
      o_store_wr   <= 1'b0;
      o_store_addr <= '0;
      o_store_wet  <= '0;
      o_store_we   <= '0;
    end else begin
      o_store_en <= w_grant_fill | w_grant_rd;
      if (w_grant_fill) begin
        o_store_wr   <= 1'b1;
        o_store_addr <= {i_fill_phi, i_fill_eta};
        o_store_wet  <= i_fill_et;
        o_store_we   <= i_fill_e;
      end else if (w_grant_rd) begin
        o_store_wr   <= 1'b0;
        o_store_addr <= {w_rd_phi, w_rd_eta};
      end
    end
  end

  // --- tag pipe p0..pRD_LAT: one-hot owner travels with the read ---
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s <= RD_LAT; s++) r_tag_p[s] <= '0;
    end else begin
      r_tag_p[0] <= w_grant_rd ? w_win_oh : '0;
      for (int s = 1; s <= RD_LAT; s++) r_tag_p[s] <= r_tag_p[s-1];
    end
  end

  // --- response stage: pass store data on a hit, otherwise hold last ---
  assign w_rsp_hit   = |r_tag_p[RD_LAT];
  assign o_rsp_valid = r_tag_p[RD_LAT];
  assign o_rsp_et    = w_rsp_hit ? i_store_et : r_rsp_et;
  assign o_rsp_e     = w_rsp_hit ? i_store_e  : r_rsp_e;

  // Keep the last delivered response so the data bus holds between strobes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_et <= '0;
      r_rsp_e  <= '0;
    end else if (w_rsp_hit) begin
      r_rsp_et <= i_store_et;
      r_rsp_e  <= i_store_e;
    end
  end

endmodule

// File: doc/calo_cell_arb.md
# calo_cell_arb

Access controller for the 32×32 calorimeter cell store, which is addressed as cell = eta + 32·phi and holds 8-bit et/e per cell. Shares the store's single command port between one fill stream (the unpacker writing cells) and NREQ lookup requesters (trigger/cluster logic reading cells). Fill writes have priority, bounded by a starvation limit. Reads are granted round-robin. Read data is returned to the owning requester after a fixed store latency, tagged by a one-hot valid.

## Interface
- NREQ, 4, number of read requesters (2..8)
- RD_LAT, 1, store read latency in cycles from command to store_et/store_e valid (1..4)
- MAXFILL, 8, max consecutive fill grants while any read is pending (1..255)

- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- fill_valid  in  1  fill beat present
- fill_eta / fill_phi  in  5 / 5  fill cell coordinates
- fill_et / fill_e  in  8 / 8  fill data
- fill_ready  out  1  fill beat accepted this cycle
- req_valid  in  NREQ  per-requester read request
- req_eta / req_phi  in  5·NREQ / 5·NREQ  packed coordinates; requester k uses bits [5k+4:5k]
- req_ready  out  NREQ  one-hot; request k accepted this cycle
- store_en  out  1  command valid to store
- store_wr  out  1  1 = put, 0 = get
- store_addr  out  10  {phi, eta}
- store_wet / store_we  out  8 / 8  write data
- store_et / store_e  in  8 / 8  read data, valid RD_LAT cycles after a get command
- rsp_valid  out  NREQ  one-hot response strobe
- rsp_et / rsp_e  out  8 / 8  response data, shared by all requesters

## Operation
- Arbitration runs every cycle on the current inputs, at most one grant per cycle. The grant is the ready/valid handshake: a beat transfers when valid & ready.
- Requesters and the fill source hold valid and fields stable until ready. Dropping valid without ready is allowed and carries no penalty.
- Decision order:
  - if fill_valid and (no req_valid or fill_run < MAXFILL): grant fill;
  - else if any req_valid: grant the read requester selected by round-robin;
  - else: no grant.
- fill_run (8-bit):
  - increments on each fill grant while any req_valid is high;
  - clears on any read grant, or on any cycle with no req_valid;
  - saturates at 255.
- Round-robin:
  - rr_ptr (log2 NREQ bits) names the highest-priority requester;
  - search order is rr_ptr, rr_ptr+1, … with wrap;
  - after granting k, rr_ptr ← (k+1) mod NREQ;
  - rr_ptr is unchanged on fill grants and idle cycles.
- Command register, loaded on the grant cycle and driven the next cycle:
  - store_en = 1;
  - store_wr = 1 for fill, 0 for read;
  - store_addr = {phi, eta} of the winner;
  - store_wet/store_we = fill data on a write, otherwise hold their last value.
  - With no grant, store_en = 0 and the other command outputs hold.
- Response tag pipe (RD_LAT+1 stages of one-hot NREQ bits):
  - stage 0 is loaded with the one-hot grant on a read grant, else zero;
  - rsp_valid = final stage;
  - rsp_et/rsp_e register store_et/store_e while that stage is nonzero, and hold otherwise.
- No backpressure on responses: a requester must accept rsp_valid when it arrives.
- A read of a cell written by an earlier fill grant returns the new data. Commands reach the store in grant order.

## Timing
- Grant in cycle N:
  - req_ready/fill_ready are high in N (combinational from inputs, fill_run and rr_ptr);
  - the store command is on the outputs in N+1;
  - for a read, rsp_valid and data appear in N+1+RD_LAT.
- Throughput: one command per cycle, with back-to-back grants to any mix of sources.
- Reset values:
  - fill_ready = 0, req_ready = 0;
  - store_en = 0, store_wr = 0, store_addr = 0, store_wet = 0, store_we = 0;
  - rsp_valid = 0, rsp_et = 0, rsp_e = 0;
  - rr_ptr = 0, fill_run = 0, tag pipe cleared.
- Reset mid-operation: in-flight reads are dropped and no rsp_valid is issued for them. Requesters must reissue.
- While rst is high, the ready outputs stay 0 even with valid inputs high.

## Test plan
- Reset, then a single read from requester 2 at eta=3, phi=7:
  - req_ready=0100 in cycle N;
  - store_en=1, store_wr=0, store_addr=0x0E3 in N+1;
  - rsp_valid=0100 with store data in N+1+RD_LAT.
- All four requesters hold valid continuously, fill idle: grants go 0,1,2,3,0,… one per cycle, rsp_valid follows the same order at latency RD_LAT+1.
- fill_valid held with requester 1 valid, MAXFILL=8:
  - fill is granted 8 consecutive cycles, then requester 1 is granted once;
  - fill resumes the next cycle and fill_run restarts from 0.
- Fill to eta=31, phi=31 with et=0xA5, then a read of the same cell in the next cycle: store_addr=0x3FF for both commands, and the read returns et=0xA5.
- Requester 0 valid, drops valid before grant because fill wins: no req_ready, no rsp_valid; rr_ptr stays 0.
- Issue 3 reads, assert rst one cycle after the last grant:
  - all outputs go to reset values immediately;
  - no rsp_valid after reset deasserts;
  - the next grant goes to requester 0.
